// File: rtl/mio_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mio_bus_ctrl
//   Registered, handshaked CPU-to-peripheral bus controller. A CPU request is
//   decoded to either the internal scratch register bank, one of NUM_SLV
//   external slaves (selected by addr[31:28] tag), or flagged as unmapped.
//   External accesses wait for the selected slave's ready and are aborted
//   with an error after TIMEOUT cycles. Every output comes straight from a
//   flop.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   cpu_req    request strobe, sampled only while cpu_busy=0
//   cpu_we     1=write, 0=read (sampled with cpu_req)
//   cpu_addr   byte address (sampled with cpu_req)
//   cpu_wdata  write data (sampled with cpu_req)
//   cpu_rdata  read data, valid with cpu_ack; holds until the next completion
//   cpu_ack    one-cycle completion pulse
//   cpu_err    with cpu_ack: unmapped address or slave timeout
//   cpu_busy   high whenever the controller is not idle
//   slv_sel    one-hot slave select, high only while waiting on a slave
//   slv_we     latched cpu_we (meaningful while slv_sel is non-zero)
//   slv_addr   latched cpu_addr
//   slv_wdata  latched cpu_wdata
//   slv_rdata  slave i read data on [32i+31:32i]
//   slv_ready  slave i completion, honoured only while slave i is selected
// -----------------------------------------------------------------------------
module mio_bus_ctrl #(
    parameter int                 NUM_SLV  = 4,
    parameter logic [4*NUM_SLV-1:0] SLV_TAGS = 16'hFED0,
    parameter logic [31:0]        SCR_BASE = 32'h0000_0900,
    parameter int                 NUM_SCR  = 4,
    parameter logic [31:0]        SCR_RST  = 32'h0000_000F,
    parameter int                 TIMEOUT  = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_wdata,
    output logic [31:0]            cpu_rdata,
    output logic                   cpu_ack,
    output logic                   cpu_err,
    output logic                   cpu_busy,
    output logic [NUM_SLV-1:0]     slv_sel,
    output logic                   slv_we,
    output logic [31:0]            slv_addr,
    output logic [31:0]            slv_wdata,
    input  logic [NUM_SLV*32-1:0]  slv_rdata,
    input  logic [NUM_SLV-1:0]     slv_ready
);

    // Scratch bank occupies NUM_SCR consecutive words starting at SCR_BASE.
    localparam int SCR_LSB = 2 + $clog2(NUM_SCR);
    localparam int SCR_AW  = (NUM_SCR > 1) ? $clog2(NUM_SCR) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_SLV-1:0]   sel_q, sel_d;
    logic                 we_q, we_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 busy_q;
    logic [31:0]          scr_q [NUM_SCR];

    logic                 scr_hit;
    logic [SCR_AW-1:0]    scr_idx;
    logic                 scr_wr;
    logic                 tag_hit;
    logic [NUM_SLV-1:0]   tag_oh;
    logic [31:0]          sel_rdata;
    logic                 sel_ready;

    // ------------------------------------------------------------------
    // Address decode (only meaningful while idle with cpu_req high)
    // ------------------------------------------------------------------
    assign scr_hit = ((cpu_addr >> SCR_LSB) == (SCR_BASE >> SCR_LSB));
    assign scr_idx = SCR_AW'((cpu_addr >> 2) & 32'(NUM_SCR - 1));

    // Walk from the top slave down so the lowest index wins on duplicate tags.
    always_comb begin
        tag_hit = 1'b0;
        tag_oh  = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (cpu_addr[31:28] == SLV_TAGS[4*i +: 4]) begin
                tag_hit = 1'b1;
                tag_oh  = NUM_SLV'(1) << i;
            end
        end
    end

    // Selected slave's data and ready; sel_q is one-hot or zero, so OR-ing
    // the masked buses is an exact mux.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) sel_rdata = sel_rdata | slv_rdata[32*i +: 32];
        end
    end

    assign sel_ready = |(slv_ready & sel_q);

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        scr_wr  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    if (scr_hit) begin
                        scr_wr  = cpu_we;
                        rdata_d = cpu_we ? 32'h0 : scr_q[scr_idx];
                        ack_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (tag_hit) begin
                        sel_d   = tag_oh;
                        cnt_d   = 8'h00;
                        state_d = S_ACCESS;
                    end else begin
                        rdata_d = 32'h0;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end

            S_ACCESS: begin
                // Ready is tested before the timeout so a ready arriving in
                // the final allowed cycle still completes without error.
                if (sel_ready) begin
                    rdata_d = we_q ? 32'h0 : sel_rdata;
                    sel_d   = '0;
                    ack_d   = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    rdata_d = 32'h0;
                    sel_d   = '0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= 8'h00;
            rdata_q <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    // NOTE: the scratch bank is a few software-visible registers with a
    // defined power-up value, so it is built from resettable flops rather
    // than an unreset RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SCR; i++) scr_q[i] <= SCR_RST;
        end else if (scr_wr) begin
            scr_q[scr_idx] <= cpu_wdata;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ack   = ack_q;
    assign cpu_err   = err_q;
    assign cpu_busy  = busy_q;
    assign slv_sel   = sel_q;
    assign slv_we    = we_q;
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mio_bus_ctrl
//   Self-checking bench for mio_bus_ctrl with default parameters. A
//   transaction-level model (address decode by tag table, scratch array,
//   latency = ready cycle or TIMEOUT) produces a per-cycle expectation queue
//   that one compare process checks on every falling edge. Literal
//   expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_mio_bus_ctrl;

    localparam int          NUM_SLV  = 4;
    localparam logic [15:0] SLV_TAGS = 16'hFED0;
    localparam logic [31:0] SCR_BASE = 32'h0000_0900;
    localparam int          NUM_SCR  = 4;
    localparam logic [31:0] SCR_RST  = 32'h0000_000F;
    localparam int          TIMEOUT  = 15;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cpu_req;
    logic                 cpu_we;
    logic [31:0]          cpu_addr;
    logic [31:0]          cpu_wdata;
    logic [31:0]          cpu_rdata;
    logic                 cpu_ack;
    logic                 cpu_err;
    logic                 cpu_busy;
    logic [NUM_SLV-1:0]   slv_sel;
    logic                 slv_we;
    logic [31:0]          slv_addr;
    logic [31:0]          slv_wdata;
    logic [NUM_SLV*32-1:0] slv_rdata;
    logic [NUM_SLV-1:0]   slv_ready;

    mio_bus_ctrl #(
        .NUM_SLV  (NUM_SLV),
        .SLV_TAGS (SLV_TAGS),
        .SCR_BASE (SCR_BASE),
        .NUM_SCR  (NUM_SCR),
        .SCR_RST  (SCR_RST),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .cpu_busy  (cpu_busy),
        .slv_sel   (slv_sel),
        .slv_we    (slv_we),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_rdata (slv_rdata),
        .slv_ready (slv_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model state and per-cycle expectation queue
    // ------------------------------------------------------------------
    typedef struct packed {
        logic               ack;
        logic               err;
        logic               busy;
        logic [NUM_SLV-1:0] sel;
        logic [31:0]        rdata;
        logic               chk_lat;
        logic               we;
        logic [31:0]        addr;
        logic [31:0]        wdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_rdata;
    logic [31:0] scr_m [NUM_SCR];
    bit          chk_en = 1'b0;

    function automatic logic [3:0] tag_of(input int i);
        logic [15:0] t;
        t = SLV_TAGS >> (4 * i);
        return t[3:0];
    endfunction

    function automatic logic [31:0] slave_val(input int i);
        return 32'hCAFE_0000 + 32'(i);
    endfunction

    function automatic void model_reset();
        m_rdata = 32'h0;
        for (int i = 0; i < NUM_SCR; i++) scr_m[i] = SCR_RST;
    endfunction

    // Slaves always present fixed, distinct data.
    initial begin
        for (int i = 0; i < NUM_SLV; i++) slv_rdata[32*i +: 32] = slave_val(i);
    end

    // Compare process: one expectation per cycle, idle when the queue is empty.
    always @(negedge clk) begin : compare
        exp_t e;
        if (chk_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e = '0;
                e.rdata = m_rdata;
            end
            check("ack",   32'(cpu_ack),  32'(e.ack));
            check("err",   32'(cpu_err),  32'(e.err));
            check("busy",  32'(cpu_busy), 32'(e.busy));
            check("sel",   32'(slv_sel),  32'(e.sel));
            check("rdata", cpu_rdata,     e.rdata);
            if (e.chk_lat) begin
                check("slv_we",    32'(slv_we), 32'(e.we));
                check("slv_addr",  slv_addr,    e.addr);
                check("slv_wdata", slv_wdata,   e.wdata);
            end
        end
    end

    // ------------------------------------------------------------------
    // One transaction. Entered and left at posedge+1 of an idle cycle, so
    // consecutive calls issue back-to-back requests. ready_at is the
    // 1-based waiting cycle in which the target asserts ready (0 = never).
    // ------------------------------------------------------------------
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int ready_at, input bit noise, input bit pulse,
                       output logic [31:0] got_rdata, output logic got_err,
                       output int sel_cycles);
        bit                 scr;
        int                 idx;
        int                 tgt;
        int                 n;
        logic [NUM_SLV-1:0] oh;
        logic [31:0]        rd;
        logic               er;
        exp_t               e;

        scr = ((addr >> 4) == (SCR_BASE >> 4));
        idx = int'((addr >> 2) & 32'(NUM_SCR - 1));
        tgt = -1;
        for (int i = NUM_SLV - 1; i >= 0; i--) if (addr[31:28] == tag_of(i)) tgt = i;

        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'hDEAD_BEEF; cpu_wdata = 32'hDEAD_BEEF;

        n  = 0;
        oh = '0;
        if (scr) begin
            er = 1'b0;
            if (we) begin
                scr_m[idx] = wdata;
                rd = 32'h0;
            end else begin
                rd = scr_m[idx];
            end
        end else if (tgt >= 0) begin
            oh = NUM_SLV'(1) << tgt;
            if (ready_at >= 1 && ready_at <= TIMEOUT) begin
                n  = ready_at;
                er = 1'b0;
                rd = we ? 32'h0 : slave_val(tgt);
            end else begin
                n  = TIMEOUT;
                er = 1'b1;
                rd = 32'h0;
            end
            for (int c = 0; c < n; c++) begin
                e = '0;
                e.busy = 1'b1; e.sel = oh; e.rdata = m_rdata;
                e.chk_lat = 1'b1; e.we = we; e.addr = addr; e.wdata = wdata;
                exp_q.push_back(e);
            end
        end else begin
            er = 1'b1;
            rd = 32'h0;
        end
        e = '0;
        e.ack = 1'b1; e.err = er; e.busy = 1'b1; e.rdata = rd;
        exp_q.push_back(e);
        m_rdata = rd;

        sel_cycles = 0;
        for (int c = 1; c <= n; c++) begin
            slv_ready = (c == ready_at) ? oh : '0;
            if (noise) slv_ready = slv_ready | ~oh;
            if (pulse && c == 1) begin
                // Would corrupt scratch word 1 if the busy controller took it.
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0904;
                cpu_wdata = 32'hBAD0_BAD0;
            end
            if (slv_sel != '0) sel_cycles++;
            @(posedge clk); #1;
            cpu_req = 1'b0;
        end
        slv_ready = '0;
        if (slv_sel != '0) sel_cycles++;
        got_rdata = cpu_rdata;
        got_err   = cpu_err;
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        logic [31:0] rd;
        logic        er;
        int          sc;

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; slv_ready = '0;
        model_reset();
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        check("rst_busy",  32'(cpu_busy), 32'h0);
        check("rst_ack",   32'(cpu_ack),  32'h0);
        check("rst_sel",   32'(slv_sel),  32'h0);
        check("rst_rdata", cpu_rdata,     32'h0);
        check("rst_addr",  slv_addr,      32'h0);
        check("rst_we",    32'(slv_we),   32'h0);

        // Scratch write then back-to-back reads
        txn(1'b1, 32'h0000_0904, 32'h1234_5678, 0, 1'b0, 1'b0, rd, er, sc);
        check("scr_wr_err", 32'(er), 32'h0);
        txn(1'b0, 32'h0000_0904, 32'h0, 0, 1'b0, 1'b0, rd, er, sc);
        check("scr_rd1", rd, 32'h1234_5678);
        check("scr_rd1_err", 32'(er), 32'h0);
        txn(1'b0, 32'h0000_0900, 32'h0, 0, 1'b0, 1'b0, rd, er, sc);
        check("scr_rd0", rd, 32'h0000_000F);
        txn(1'b0, 32'h0000_090C, 32'h0, 0, 1'b0, 1'b0, rd, er, sc);
        check("scr_rd3", rd, 32'h0000_000F);

        // Slave 1 (tag D) ready in its third waiting cycle
        txn(1'b0, 32'hD000_0000, 32'h0, 3, 1'b0, 1'b0, rd, er, sc);
        check("s1_rdata", rd, 32'hCAFE_0001);
        check("s1_err", 32'(er), 32'h0);
        check("s1_selcyc", 32'(sc), 32'd3);

        // Slave 2 (tag E) at minimum latency, others' ready toggling
        txn(1'b0, 32'hE000_0000, 32'h0, 1, 1'b1, 1'b0, rd, er, sc);
        check("s2_rdata", rd, 32'hCAFE_0002);
        check("s2_selcyc", 32'(sc), 32'd1);

        // Slave 3 write: rdata reported as zero
        txn(1'b1, 32'hF000_0040, 32'h5A5A_A5A5, 2, 1'b1, 1'b0, rd, er, sc);
        check("s3_wr_rdata", rd, 32'h0);
        check("s3_wr_err", 32'(er), 32'h0);

        // Slave 0 (tag 0) outside the scratch window
        txn(1'b0, 32'h0000_0100, 32'h0, 1, 1'b0, 1'b0, rd, er, sc);
        check("s0_rdata", rd, 32'hCAFE_0000);

        // Timeout: never ready
        txn(1'b0, 32'hD000_0010, 32'h0, 0, 1'b0, 1'b0, rd, er, sc);
        check("to_err", 32'(er), 32'h1);
        check("to_rdata", rd, 32'h0);
        check("to_selcyc", 32'(sc), 32'd15);

        // Ready in the last allowed cycle wins over timeout
        txn(1'b0, 32'hD000_0010, 32'h0, 15, 1'b0, 1'b0, rd, er, sc);
        check("to_edge_err", 32'(er), 32'h0);
        check("to_edge_rdata", rd, 32'hCAFE_0001);

        // Ready one cycle too late
        txn(1'b0, 32'hE000_0004, 32'h0, 16, 1'b0, 1'b0, rd, er, sc);
        check("to_late_err", 32'(er), 32'h1);

        // Unmapped
        txn(1'b0, 32'h3000_0000, 32'h0, 0, 1'b0, 1'b0, rd, er, sc);
        check("unm_err", 32'(er), 32'h1);
        check("unm_selcyc", 32'(sc), 32'd0);
        check("unm_rdata", rd, 32'h0);

        // Request pulse during ACCESS must be ignored
        txn(1'b0, 32'hE000_0000, 32'h0, 4, 1'b0, 1'b1, rd, er, sc);
        check("pulse_rdata", rd, 32'hCAFE_0002);
        txn(1'b0, 32'h0000_0904, 32'h0, 0, 1'b0, 1'b0, rd, er, sc);
        check("pulse_scr", rd, 32'h1234_5678);

        // Reset in the third waiting cycle of an access
        begin : mid_reset
            exp_t e;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hE000_0000; cpu_wdata = 32'h0;
            @(posedge clk); #1;
            cpu_req = 1'b0;
            for (int c = 0; c < 3; c++) begin
                e = '0;
                e.busy = 1'b1; e.sel = 4'b0100; e.rdata = m_rdata;
                e.chk_lat = 1'b1; e.addr = 32'hE000_0000;
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst = 1'b1;
            model_reset();
            @(posedge clk); #1;
            rst = 1'b0;
            check("mrst_sel",  32'(slv_sel),  32'h0);
            check("mrst_busy", 32'(cpu_busy), 32'h0);
            check("mrst_ack",  32'(cpu_ack),  32'h0);
            @(posedge clk); #1;
            check("mrst_noack", 32'(cpu_ack), 32'h0);
        end

        txn(1'b0, 32'h0000_0904, 32'h0, 0, 1'b0, 1'b0, rd, er, sc);
        check("mrst_scr", rd, 32'h0000_000F);
        txn(1'b0, 32'hD000_0000, 32'h0, 2, 1'b0, 1'b0, rd, er, sc);
        check("post_rst_s1", rd, 32'hCAFE_0001);

        @(posedge clk); #1;
        @(negedge clk);
        if (exp_q.size() != 0) check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "bench time limit exceeded");
    end

endmodule
